// File: rtl/wasm_ifetch_pkg.sv
// Shared definitions for the instruction-fetch window buffer: default sizes,
// width derivation helpers and the protocol-error cause encoding.
package wasm_ifetch_pkg;

    localparam int DEF_PC_W   = 16;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_RD_WIN = 16;
    localparam int DEF_WR_WIN = 4;

    // Buffer index width: DEPTH is a power of two, so this is exact.
    function automatic int calc_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: one extra bit so count can reach DEPTH itself.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Why proto_err fired. Only the flag is exported today; the encoding is
    // kept here so a cause register can be added without touching callers.
    typedef enum logic [1:0] {
        PERR_NONE       = 2'd0,
        PERR_OVERSHIFT  = 2'd1,
        PERR_WR_NOT_RDY = 2'd2,
        PERR_RSVD       = 2'd3
    } perr_cause_e;

endpackage

// File: rtl/instr_ptr_ctrl.sv
// Pointer/occupancy controller for the instruction window buffer: tracks the
// read PC, write PC and byte count, handles jump-with-flush and the refetch
// pulse, and keeps the sticky protocol-error flag.
module instr_ptr_ctrl
    import wasm_ifetch_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int RD_WIN = DEF_RD_WIN,
    parameter int WR_WIN = DEF_WR_WIN,
    localparam int IDX_W = calc_idx_w(DEPTH),
    localparam int CNT_W = calc_cnt_w(DEPTH),
    localparam int WL_W  = $clog2(WR_WIN),
    localparam int SH_W  = $clog2(RD_WIN),
    localparam int AV_W  = $clog2(RD_WIN) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_vld_i,
    input  logic [WL_W-1:0]  wr_len_m1_i,
    input  logic             shift_vld_i,
    input  logic [SH_W-1:0]  shift_m1_i,
    input  logic             hlt_i,
    input  logic             jump_en_i,
    input  logic [PC_W-1:0]  jump_addr_i,
    output logic             wr_rdy_o,
    output logic             wr_fire_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic [IDX_W-1:0] rd_idx_o,
    output logic [PC_W-1:0]  rd_pc_o,
    output logic [AV_W-1:0]  rd_avail_o,
    output logic             refetch_vld_o,
    output logic [PC_W-1:0]  refetch_pc_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             proto_err_o
);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] WR_WIN_C = CNT_W'(WR_WIN);
    localparam logic [CNT_W-1:0] RD_WIN_C = CNT_W'(RD_WIN);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  rd_pc_q, rd_pc_d;
    logic [PC_W-1:0]  wr_pc_q, wr_pc_d;
    logic [PC_W-1:0]  refetch_pc_q, refetch_pc_d;
    logic             refetch_vld_q, refetch_vld_d;
    logic             proto_err_q, proto_err_d;

    logic [CNT_W-1:0] free_cnt;
    logic [AV_W-1:0]  rd_avail;
    logic [AV_W-1:0]  rlen;
    logic [WL_W:0]    wlen;
    logic             wr_rdy;
    logic             wr_fire;
    logic             rd_req;
    logic             overshift;
    logic             rd_fire;
    perr_cause_e      cause;

    // Handshake decode from registered state; a jump discards same-cycle
    // writes and shifts, so neither fires nor flags an error under jump_en.
    always_comb begin
        free_cnt  = DEPTH_C - count_q;
        wr_rdy    = (free_cnt >= WR_WIN_C);
        rd_avail  = (count_q >= RD_WIN_C) ? AV_W'(RD_WIN) : count_q[AV_W-1:0];
        rlen      = {1'b0, shift_m1_i} + AV_W'(1);
        wlen      = {1'b0, wr_len_m1_i} + (WL_W+1)'(1);
        rd_req    = shift_vld_i & ~hlt_i & ~jump_en_i;
        overshift = (rlen > rd_avail);
        rd_fire   = rd_req & ~overshift;
        wr_fire   = wr_vld_i & wr_rdy & ~jump_en_i;
        cause     = PERR_NONE;
        if (!jump_en_i) begin
            if (wr_vld_i && !wr_rdy) begin
                cause = PERR_WR_NOT_RDY;
            end else if (rd_req && overshift) begin
                cause = PERR_OVERSHIFT;
            end
        end
    end

    // Next-state: jump flushes everything; otherwise write and read move
    // their pointers independently and count takes both in one update.
    always_comb begin
        rd_pc_d       = rd_pc_q;
        wr_pc_d       = wr_pc_q;
        count_d       = count_q;
        refetch_pc_d  = refetch_pc_q;
        refetch_vld_d = 1'b0;
        proto_err_d   = proto_err_q | (cause != PERR_NONE);
        if (jump_en_i) begin
            rd_pc_d       = jump_addr_i;
            wr_pc_d       = jump_addr_i;
            refetch_pc_d  = jump_addr_i;
            count_d       = '0;
            refetch_vld_d = 1'b1;
        end else begin
            rd_pc_d = rd_pc_q + (rd_fire ? PC_W'(rlen) : '0);
            wr_pc_d = wr_pc_q + (wr_fire ? PC_W'(wlen) : '0);
            count_d = count_q + (wr_fire ? CNT_W'(wlen) : '0)
                              - (rd_fire ? CNT_W'(rlen) : '0);
        end
    end

    // Pointer, count and flag registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pc_q       <= '0;
            wr_pc_q       <= '0;
            count_q       <= '0;
            refetch_pc_q  <= '0;
            refetch_vld_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            rd_pc_q       <= rd_pc_d;
            wr_pc_q       <= wr_pc_d;
            count_q       <= count_d;
            refetch_pc_q  <= refetch_pc_d;
            refetch_vld_q <= refetch_vld_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign wr_rdy_o      = wr_rdy;
    assign wr_fire_o     = wr_fire & ~rst_i;
    assign wr_idx_o      = wr_pc_q[IDX_W-1:0];
    assign rd_idx_o      = rd_pc_q[IDX_W-1:0];
    assign rd_pc_o       = rd_pc_q;
    assign rd_avail_o    = rd_avail;
    assign refetch_vld_o = refetch_vld_q;
    assign refetch_pc_o  = refetch_pc_q;
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == DEPTH_C);
    assign proto_err_o   = proto_err_q;

endmodule

// File: rtl/instr_window_fifo.sv
// Circular instruction byte buffer between the loader and the decode stage.
// Holds the byte storage, the write-lane decode and the read-window mux;
// pointer bookkeeping lives in instr_ptr_ctrl.
//
// Handshakes: a write beat transfers on a cycle where wr_vld and wr_rdy are
// both high (and jump_en is low); wr_rdy depends only on registered state, so
// the loader may hold wr_vld high and wait. A shift transfers when shift_vld is
// high with hlt and jump_en low; there is no ready, and asking for more bytes
// than rd_avail is a protocol error, as is wr_vld while wr_rdy is low.
module instr_window_fifo
    import wasm_ifetch_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int RD_WIN = DEF_RD_WIN,
    parameter int WR_WIN = DEF_WR_WIN,
    localparam int IDX_W = calc_idx_w(DEPTH),
    localparam int WL_W  = $clog2(WR_WIN),
    localparam int SH_W  = $clog2(RD_WIN),
    localparam int AV_W  = $clog2(RD_WIN) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WL_W-1:0]          wr_len_m1,
    input  logic [WR_WIN*BYTE_W-1:0] wr_data,
    output logic [RD_WIN*BYTE_W-1:0] rd_data,
    output logic [AV_W-1:0]          rd_avail,
    output logic [PC_W-1:0]          rd_pc,
    input  logic                     shift_vld,
    input  logic [SH_W-1:0]          shift_m1,
    input  logic                     hlt,
    input  logic                     jump_en,
    input  logic [PC_W-1:0]          jump_addr,
    output logic                     refetch_vld,
    output logic [PC_W-1:0]          refetch_pc,
    output logic                     empty,
    output logic                     full,
    output logic                     proto_err,
    input  logic [IDX_W-1:0]         dbg_addr,
    output logic [BYTE_W-1:0]        dbg_data
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] dbg_data_q;
    logic              wr_fire;
    logic [IDX_W-1:0]  wr_base;
    logic [IDX_W-1:0]  rd_base;
    logic [IDX_W-1:0]  wr_idx [WR_WIN];
    logic [IDX_W-1:0]  rd_idx [RD_WIN];
    logic [WR_WIN-1:0] wr_en;

    instr_ptr_ctrl #(
        .PC_W   (PC_W),
        .DEPTH  (DEPTH),
        .RD_WIN (RD_WIN),
        .WR_WIN (WR_WIN)
    ) u_ptr_ctrl (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_vld_i      (wr_vld),
        .wr_len_m1_i   (wr_len_m1),
        .shift_vld_i   (shift_vld),
        .shift_m1_i    (shift_m1),
        .hlt_i         (hlt),
        .jump_en_i     (jump_en),
        .jump_addr_i   (jump_addr),
        .wr_rdy_o      (wr_rdy),
        .wr_fire_o     (wr_fire),
        .wr_idx_o      (wr_base),
        .rd_idx_o      (rd_base),
        .rd_pc_o       (rd_pc),
        .rd_avail_o    (rd_avail),
        .refetch_vld_o (refetch_vld),
        .refetch_pc_o  (refetch_pc),
        .empty_o       (empty),
        .full_o        (full),
        .proto_err_o   (proto_err)
    );

    // Per-lane write index and enable; indices wrap naturally in IDX_W bits.
    always_comb begin
        for (int j = 0; j < WR_WIN; j++) begin
            wr_idx[j] = wr_base + IDX_W'(j);
            wr_en[j]  = wr_fire && (WL_W'(j) <= wr_len_m1);
        end
    end

    // Byte storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < WR_WIN; j++) begin
            if (wr_en[j]) begin
                mem_q[wr_idx[j]] <= wr_data[j*BYTE_W +: BYTE_W];
            end
        end
    end

    // Read window: byte i comes from rd_pc+i, wrapping across index 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < RD_WIN; i++) begin
            rd_idx[i] = rd_base + IDX_W'(i);
            rd_data[i*BYTE_W +: BYTE_W] = mem_q[rd_idx[i]];
        end
    end

    // Registered debug read; sees the pre-write byte on a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_data_q <= '0;
        end else begin
            dbg_data_q <= mem_q[dbg_addr];
        end
    end

    assign dbg_data = dbg_data_q;

endmodule
